pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register for the RISC-V Lite core. It is the successor to the hard-wired per-stage registers and replaces the global `en` with a per-stage valid/ready handshake. It adds an optional skid buffer, synchronous flush with NOP injection, occupancy reporting and a saturating stall counter. It is instantiated once per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage payload packed into one vector.

Parameters:
WIDTH, 32, payload width in bits (≥1)
SKID_EN, 1, 1 = two-entry (main + skid), in_ready registered; 0 = single entry, in_ready combinational
RESET_VAL, '0, payload value loaded on reset (WIDTH bits)
NOP_VAL, '0, payload value loaded on flush, e.g. M_ctrl with CS=1 and all other fields 0 (WIDTH bits)
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; kills all held entries
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept
in_data  in  WIDTH  upstream payload
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_data  out  WIDTH  main entry payload
occupancy  out  2  number of valid entries, 0..2
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating
stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rstn low, async):
  - state = EMPTY; main = skid = RESET_VAL; stall_cnt = 0.
  - out_valid = 0; occupancy = 0; out_data = RESET_VAL.
  - in_ready = 1 once state is EMPTY; in_valid is ignored while rstn is low.
- States (SKID_EN=1): EMPTY (0 entries), BUSY (main valid), SKID (main + skid valid).
  - EMPTY: in_fire -> BUSY, main <= in_data.
  - BUSY, in_fire & out_fire -> BUSY, main <= in_data.
  - BUSY, in_fire & !out_ready -> SKID, skid <= in_data.
  - BUSY, !in_fire & out_fire -> EMPTY.
  - BUSY, neither -> hold.
  - SKID, out_fire -> BUSY, main <= skid. Otherwise hold.
- Outputs (SKID_EN=1):
  - in_ready = (state != SKID), decoded from the state flop only. No combinational path from out_ready.
  - out_valid = (state != EMPTY); out_data = main.
- SKID_EN=0: states EMPTY/BUSY only.
  - in_ready = !out_valid | out_ready (combinational).
  - BUSY with in_fire & out_fire reloads main. BUSY with out_fire and no in_fire goes to EMPTY.
- Latency: 1 cycle from in_fire to out_valid when the stage is EMPTY. Throughput is 1 item per cycle under continuous out_ready.
- Ordering: FIFO. The skid entry always drains before any newer item.
- Stability: while out_valid & !out_ready, out_data and out_valid hold constant.
- Flush (synchronous, priority over all handshake activity):
  - Next state = EMPTY; main = skid = NOP_VAL.
  - Any in_fire in the flush cycle is discarded, and out_fire in that cycle is still considered consumed by downstream.
  - in_ready is not gated by flush.
- Occupancy: 0/1/2 for EMPTY/BUSY/SKID. It never exceeds 1 when SKID_EN=0.
- stall_cnt:
  - Increments when out_valid & !out_ready and saturates at 2^CNT_W−1.
  - stall_clr has priority over increment and sets it to 0.
  - flush does not clear it.
- Reset mid-operation: all entries are lost immediately, with no draining.
- Illegal combination: in_valid in the SKID state is not accepted (in_ready = 0). Upstream must hold the payload.

Decomposition:
- my_pkg: stage_state_e enum (EMPTY, BUSY, SKID); packed stage payload structs built from WB_ctrl / M_ctrl / EX_ctrl; per-stage NOP constants (e.g. ID_EX_NOP).
- Sub-module: sat_counter (CNT_W, inc, clr, count) for stall_cnt.
- The main datapath stays in one module.

Test Plan:
1. Reset with WIDTH=8, RESET_VAL=8'hA5 -> out_valid=0, out_data=A5, occupancy=0, in_ready=1, stall_cnt=0, all asynchronously before the next clk edge.
2. Streaming: 10 items 0..9, in_valid and out_ready held high -> out_data = 0..9 on consecutive cycles, 1-cycle latency, occupancy stays 1.
3. Backpressure (SKID_EN=1): send 0x11, 0x22 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x11 held. Raise out_ready -> 0x11, then 0x22, then EMPTY; stall_cnt equals the cycles held.
4. Flush with occupancy=2 and in_valid=1 carrying 0x33 (NOP_VAL=8'h13) -> next cycle out_valid=0, occupancy=0, main=0x13; 0x33 never appears at the output.
5. SKID_EN=0: out_ready=0 with main valid -> in_ready=0 in the same cycle. Set out_ready=1 -> in_ready=1 combinationally and main is reloaded with no bubble.
6. CNT_W=3: hold a stall for 10 cycles -> stall_cnt saturates at 7. Pulse stall_clr during the stall -> stall_cnt=0, then resumes counting.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the inter-stage pipeline registers: stage state encoding,
// packed per-boundary payloads and the bubble (NOP) values injected on flush.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic       cs;
    logic       we;
    logic [1:0] size;
  } m_ctrl_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       branch;
  } ex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    wb_ctrl_t    wb;
    m_ctrl_t     m;
    ex_ctrl_t    ex;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    wb_ctrl_t    wb;
    m_ctrl_t     m;
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    wb_ctrl_t    wb;
    logic [31:0] rdata;
    logic [31:0] alu_res;
    logic [4:0]  rd;
  } mem_wb_t;

  // Memory stage treats cs=1 with we=0 as an idle slot, so bubbles carry it.
  localparam m_ctrl_t M_CTRL_NOP = '{cs: 1'b1, we: 1'b0, size: 2'b00};

  localparam if_id_t IF_ID_NOP = '{pc: 32'h0, instr: 32'h0000_0013};

  localparam id_ex_t ID_EX_NOP = '{
    wb: '0, m: M_CTRL_NOP, ex: '0, pc: 32'h0,
    rs1_val: 32'h0, rs2_val: 32'h0, imm: 32'h0, rd: 5'h0
  };

  localparam ex_mem_t EX_MEM_NOP = '{
    wb: '0, m: M_CTRL_NOP, alu_res: 32'h0, rs2_val: 32'h0, rd: 5'h0
  };

  localparam mem_wb_t MEM_WB_NOP = '{
    wb: '0, rdata: 32'h0, alu_res: 32'h0, rd: 5'h0
  };

  function automatic logic [1:0] occ_of(input stage_state_e s);
    case (s)
      BUSY:    occ_of = 2'd1;
      SKID:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count reflects inc/clr one cycle later; no backpressure.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional skid entry, flush-to-NOP and stall counter.
// Latency 1 cycle when empty; with SKID_EN in_ready is a pure flop decode, else it follows out_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter bit               SKID_EN   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] NOP_VAL   = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire && SKID_EN) begin
            // Only reachable with a skid entry: without one, in_fire here implies out_fire.
            state_d   = SKID;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d        = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    occupancy = occ_of(state_q);
    if (SKID_EN) begin
      in_ready = (state_q != SKID);
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      main_q <= NOP_VAL;
      skid_q <= NOP_VAL;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (out_valid & ~out_ready),
    .clr   (stall_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid instance (a_*) and single-entry instance (b_*),
// with per-instance scoreboards fed on in_fire and drained on out_fire.
module tb_pipe_stage_reg;

  logic       clk = 1'b0;
  logic       rstn;

  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall_clr;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  logic [2:0] a_stall;

  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_occ;
  logic [2:0] b_stall;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(8), .SKID_EN(1'b1), .RESET_VAL(8'hA5), .NOP_VAL(8'h13), .CNT_W(3)
  ) u_dut_skid (
    .clk(clk), .rstn(rstn), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall), .stall_clr(a_stall_clr)
  );

  pipe_stage_reg #(
    .WIDTH(8), .SKID_EN(1'b0), .RESET_VAL(8'hA5), .NOP_VAL(8'h13), .CNT_W(3)
  ) u_dut_single (
    .clk(clk), .rstn(rstn), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall), .stall_clr(b_stall_clr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_a(input logic iv, input logic [7:0] d, input logic ordy,
                         input logic fl, input logic clr);
    a_in_valid  = iv;
    a_in_data   = d;
    a_out_ready = ordy;
    a_flush     = fl;
    a_stall_clr = clr;
  endtask

  task automatic settle_a();
    logic [7:0] exp;
    #1;
    if (a_out_valid && a_out_ready) begin
      chk("sb_a_avail", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        exp = q_a.pop_front();
        chk("sb_a_data", 32'(a_out_data), 32'(exp));
      end
    end
    if (a_flush) q_a.delete();
    else if (a_in_valid && a_in_ready) q_a.push_back(a_in_data);
  endtask

  task automatic step_a(input logic iv, input logic [7:0] d, input logic ordy,
                        input logic fl, input logic clr);
    @(negedge clk);
    drive_a(iv, d, ordy, fl, clr);
    settle_a();
  endtask

  task automatic drive_b(input logic iv, input logic [7:0] d, input logic ordy);
    b_in_valid  = iv;
    b_in_data   = d;
    b_out_ready = ordy;
  endtask

  task automatic settle_b();
    logic [7:0] exp;
    #1;
    if (b_out_valid && b_out_ready) begin
      chk("sb_b_avail", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        exp = q_b.pop_front();
        chk("sb_b_data", 32'(b_out_data), 32'(exp));
      end
    end
    if (b_in_valid && b_in_ready) q_b.push_back(b_in_data);
  endtask

  task automatic step_b(input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    drive_b(iv, d, ordy);
    settle_b();
  endtask

  initial begin
    rstn = 1'b1;
    drive_a(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    drive_b(1'b1, 8'hEE, 1'b0);
    b_flush     = 1'b0;
    b_stall_clr = 1'b0;

    // Async reset, observed before any clock edge, with in_valid asserted.
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data",  32'(a_out_data),  32'hA5);
    chk("rst_occ",       32'(a_occ),       32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_stall",     32'(a_stall),     32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    chk("rst_b_stall",   32'(b_stall),     32'd0);
    #10;
    chk("rst_hold_valid", 32'(a_out_valid), 32'd0);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
    #2 rstn = 1'b1;

    // Streaming 0..9 at full rate.
    for (int i = 0; i < 10; i++) begin
      step_a(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        chk("stream_valid", 32'(a_out_valid), 32'd1);
        chk("stream_occ",   32'(a_occ),       32'd1);
      end
    end
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("stream_end_valid", 32'(a_out_valid), 32'd0);

    // Backpressure into the skid entry; upstream keeps offering 0x99 while full.
    step_a(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    chk("bp_occ",      32'(a_occ),      32'd2);
    chk("bp_in_ready", 32'(a_in_ready), 32'd0);
    chk("bp_data",     32'(a_out_data), 32'h11);
    step_a(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_data",  32'(a_out_data),  32'h11);
    chk("bp_hold_valid", 32'(a_out_valid), 32'd1);
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bp_stall_cnt", 32'(a_stall), 32'd3);
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bp_empty_valid", 32'(a_out_valid), 32'd0);
    chk("bp_empty_occ",   32'(a_occ),       32'd0);

    // Flush while full, with 0x33 offered.
    step_a(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    chk("fl_pre_occ", 32'(a_occ), 32'd2);
    step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("fl_valid", 32'(a_out_valid), 32'd0);
    chk("fl_occ",   32'(a_occ),       32'd0);
    chk("fl_nop",   32'(a_out_data),  32'h13);

    // Flush while busy: 0x66 leaves in the flush cycle, 0x33 is accepted but discarded.
    step_a(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    chk("fl2_in_ready", 32'(a_in_ready), 32'd1);
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fl2_valid", 32'(a_out_valid), 32'd0);
    chk("fl2_nop",   32'(a_out_data),  32'h13);
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fl2_still_empty", 32'(a_out_valid), 32'd0);

    // Stall counter saturation and clear (CNT_W=3).
    step_a(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (k == 5)  chk("sat_mid",  32'(a_stall), 32'd4);
      if (k == 11) chk("sat_full", 32'(a_stall), 32'd7);
    end
    step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("sat_cleared", 32'(a_stall), 32'd0);
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("sat_resumed", 32'(a_stall), 32'd1);
    step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("sat_drained", 32'(a_out_valid), 32'd0);

    // Reset mid-operation drops the held entry immediately.
    step_a(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_pre_valid", 32'(a_out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_occ",   32'(a_occ),       32'd0);
    chk("mid_rst_data",  32'(a_out_data),  32'hA5);
    q_a.delete();
    #1 rstn = 1'b1;

    // Single-entry variant: combinational in_ready, reload without a bubble.
    step_b(1'b1, 8'h21, 1'b0);
    @(negedge clk);
    drive_b(1'b1, 8'h31, 1'b0);
    #1;
    chk("b_rdy_stall", 32'(b_in_ready), 32'd0);
    chk("b_occ_busy",  32'(b_occ),      32'd1);
    b_out_ready = 1'b1;
    settle_b();
    chk("b_rdy_comb", 32'(b_in_ready), 32'd1);
    step_b(1'b1, 8'h41, 1'b1);
    chk("b_no_bubble", 32'(b_out_valid), 32'd1);
    chk("b_occ_max",   32'(b_occ),       32'd1);
    step_b(1'b0, 8'h00, 1'b1);
    step_b(1'b0, 8'h00, 1'b1);
    chk("b_empty", 32'(b_out_valid), 32'd0);

    chk("sb_a_left", 32'(q_a.size()), 32'd0);
    chk("sb_b_left", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
